// File: rtl/rsnn_ctrl_subsystem_if.sv
// Pin-side bundle of the RSNN control front-end: async enables, serial load
// inputs, spike inputs and everything handed to the core.
interface rsnn_ctrl_if #(
  parameter int N_IN       = 3,
  parameter int PARAM_BITS = 312,
  parameter int TS_W       = 8
);
  logic                  system_enable;
  logic                  spike_input_reg_enable;
  logic                  rsnn_enable;
  logic                  load_params;
  logic                  data_in;
  logic [N_IN-1:0]       input_spikes;
  logic [N_IN-1:0]       registered_spikes;
  logic [PARAM_BITS-1:0] params_out;
  logic                  params_valid;
  logic                  core_enable;
  logic                  data_written;
  logic                  end_writing;
  logic                  load_error;
  logic [TS_W-1:0]       timestep;
  logic [1:0]            dbg_state;

  // data_written and end_writing are single-cycle strobes with no back-pressure:
  // a bit on data_in is consumed at the clock edge that closes a data_written
  // cycle, and end_writing marks the cycle in which params_out is being replaced.
  modport master (
    output system_enable, spike_input_reg_enable, rsnn_enable, load_params,
    output data_in, input_spikes,
    input  registered_spikes, params_out, params_valid, core_enable,
    input  data_written, end_writing, load_error, timestep, dbg_state
  );

  modport slave (
    input  system_enable, spike_input_reg_enable, rsnn_enable, load_params,
    input  data_in, input_spikes,
    output registered_spikes, params_out, params_valid, core_enable,
    output data_written, end_writing, load_error, timestep, dbg_state
  );
endinterface

// File: rtl/rsnn_ctrl_subsystem.sv
// Control front-end for the RSNN core: enable synchronizers, spike register,
// serial parameter loader with shadow/commit, and the core timestep counter.
module rsnn_ctrl_subsystem #(
  parameter int N_IN        = 3,
  parameter int PARAM_BITS  = 312,
  parameter int SYNC_STAGES = 2,
  parameter int TS_W        = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  rsnn_ctrl_if.slave  bus
);

  localparam int              BC_W     = (PARAM_BITS > 2) ? $clog2(PARAM_BITS) : 1;
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(PARAM_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sync_sys;
  logic [SYNC_STAGES-1:0] r_sync_spk;
  logic [SYNC_STAGES-1:0] r_sync_run;
  logic [SYNC_STAGES-1:0] r_sync_ld;
  logic [SYNC_STAGES-1:0] r_warm;
  logic                   r_ld_prev;
  logic                   r_ld_armed;

  logic [BC_W-1:0]        r_bit_cnt;
  logic [PARAM_BITS-1:0]  r_shadow;
  logic [PARAM_BITS-1:0]  r_params;
  logic                   r_params_valid;
  logic                   r_load_error;
  logic [N_IN-1:0]        r_spikes;
  logic                   r_core_en;
  logic [TS_W-1:0]        r_timestep;

  logic                   w_s_sys;
  logic                   w_s_spk;
  logic                   w_s_run;
  logic                   w_s_ld;
  logic                   w_start;
  logic                   w_load_go;
  logic                   w_shift;
  logic                   w_abort;
  logic                   w_commit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync_sys <= '0;
      r_sync_spk <= '0;
      r_sync_run <= '0;
      r_sync_ld  <= '0;
      r_warm     <= '0;
    end else begin
      r_sync_sys <= {r_sync_sys[SYNC_STAGES-2:0], bus.system_enable};
      r_sync_spk <= {r_sync_spk[SYNC_STAGES-2:0], bus.spike_input_reg_enable};
      r_sync_run <= {r_sync_run[SYNC_STAGES-2:0], bus.rsnn_enable};
      r_sync_ld  <= {r_sync_ld[SYNC_STAGES-2:0],  bus.load_params};
      r_warm     <= {r_warm[SYNC_STAGES-2:0],     1'b1};
    end
  end

  assign w_s_sys = r_sync_sys[SYNC_STAGES-1];
  assign w_s_spk = r_sync_spk[SYNC_STAGES-1];
  assign w_s_run = r_sync_run[SYNC_STAGES-1];
  assign w_s_ld  = r_sync_ld[SYNC_STAGES-1];

  // The reset value of the synchronizer is not a real low level on the pin, so
  // an edge only counts once s_ld has been seen low after the chain has flushed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ld_prev  <= 1'b0;
      r_ld_armed <= 1'b0;
    end else begin
      r_ld_prev  <= w_s_ld;
      r_ld_armed <= r_ld_armed | (r_warm[SYNC_STAGES-1] & ~w_s_ld);
    end
  end

  assign w_start = w_s_ld & ~r_ld_prev & r_ld_armed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_go   = 1'b0;
    w_shift     = 1'b0;
    w_abort     = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start && w_s_sys) begin
          w_state_nxt = ST_LOAD;
          w_load_go   = 1'b1;
        end
      end
      ST_LOAD: begin
        if (!w_s_sys) begin
          w_state_nxt = ST_IDLE;
          w_abort     = 1'b1;
        end else begin
          w_shift = 1'b1;
          if (r_bit_cnt == LAST_BIT) begin
            w_state_nxt = ST_COMMIT;
          end
        end
      end
      ST_COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_cnt <= '0;
      r_shadow  <= '0;
    end else begin
      if (w_load_go || w_abort || (w_shift && (r_bit_cnt == LAST_BIT))) begin
        r_bit_cnt <= '0;
      end else if (w_shift) begin
        r_bit_cnt <= r_bit_cnt + BC_W'(1);
      end
      if (w_shift) begin
        r_shadow <= {r_shadow[PARAM_BITS-2:0], bus.data_in};
      end
    end
  end

  // The core only ever sees a fully shifted shadow; aborts leave params untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_params       <= '0;
      r_params_valid <= 1'b0;
      r_load_error   <= 1'b0;
    end else begin
      if (w_commit) begin
        r_params       <= r_shadow;
        r_params_valid <= 1'b1;
      end
      if (w_load_go) begin
        r_load_error <= 1'b0;
      end else if (w_abort) begin
        r_load_error <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_spikes   <= '0;
      r_core_en  <= 1'b0;
      r_timestep <= '0;
    end else begin
      if (w_s_sys && w_s_spk) begin
        r_spikes <= bus.input_spikes;
      end
      r_core_en <= w_s_sys & w_s_run & r_params_valid;
      if (!w_s_run) begin
        r_timestep <= '0;
      end else if (r_core_en) begin
        r_timestep <= r_timestep + TS_W'(1);
      end
    end
  end

  assign bus.registered_spikes = r_spikes;
  assign bus.params_out        = r_params;
  assign bus.params_valid      = r_params_valid;
  assign bus.core_enable       = r_core_en;
  assign bus.data_written      = w_shift;
  assign bus.end_writing       = w_commit;
  assign bus.load_error        = r_load_error;
  assign bus.timestep          = r_timestep;
  assign bus.dbg_state         = r_state;

endmodule

// File: tb/tb_rsnn_ctrl_subsystem.sv
// Self-checking bench for rsnn_ctrl_subsystem: directed scenarios plus random
// good/aborted loads compared against a simple behavioural model.
module tb_rsnn_ctrl_subsystem;

  localparam int N  = 3;
  localparam int PB = 8;
  localparam int SS = 2;
  localparam int TW = 4;

  logic clk;
  logic reset_n;

  rsnn_ctrl_if #(.N_IN(N), .PARAM_BITS(PB), .TS_W(TW)) bus ();

  rsnn_ctrl_subsystem #(
    .N_IN(N), .PARAM_BITS(PB), .SYNC_STAGES(SS), .TS_W(TW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // behavioural model of what the core should see
  logic [PB-1:0] m_params;
  logic          m_valid;
  logic          m_err;
  logic [PB-1:0] exp_q[$];

  // strobe monitor, sampled on the falling edge
  int cyc     = 0;
  int dw_cnt  = 0;
  int dw_last = 0;
  int ew_cnt  = 0;
  int ew_cyc  = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.data_written === 1'b1) begin
      dw_cnt  = dw_cnt + 1;
      dw_last = cyc;
    end
    if (bus.end_writing === 1'b1) begin
      ew_cnt = ew_cnt + 1;
      ew_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Streams w MSB-first, advancing one bit each time a data_written cycle closes.
  // abort_after>0 drops system_enable once that many bits have been taken.
  task automatic drive_load(input logic [PB-1:0] w, input int abort_after);
    int  idx;
    int  cycles;
    int  post;
    int  ew0;
    bit  dropped;
    bit  done;
    idx     = 0;
    cycles  = 0;
    post    = 0;
    dropped = 1'b0;
    done    = 1'b0;
    ew0     = ew_cnt;
    bus.data_in     = w[PB-1];
    bus.load_params = 1'b1;
    while (!done && cycles < 100) begin
      @(negedge clk);
      if (bus.data_written === 1'b1) idx++;
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == 4) bus.load_params = 1'b0;
      if (idx < PB) bus.data_in = w[PB-1-idx];
      if (abort_after > 0 && idx == abort_after) begin
        bus.system_enable = 1'b0;
        dropped = 1'b1;
      end
      if (dropped) post++;
      if (abort_after == 0 && ew_cnt != ew0) done = 1'b1;
      if (abort_after > 0 && post >= 6) done = 1'b1;
    end
    bus.load_params = 1'b0;
  endtask

  task automatic run_load(input string tag, input logic [PB-1:0] w, input int abort_after);
    int dw0;
    int ew0;
    logic [PB-1:0] exp_p;
    dw0 = dw_cnt;
    ew0 = ew_cnt;
    drive_load(w, abort_after);
    if (abort_after == 0) begin
      m_params = w;
      m_valid  = 1'b1;
      m_err    = 1'b0;
    end else begin
      m_err = 1'b1;
    end
    exp_q.push_back(m_params);
    exp_p = exp_q.pop_front();
    chk({tag, "_params"}, bus.params_out, exp_p);
    chk({tag, "_valid"}, bus.params_valid, m_valid);
    chk({tag, "_err"}, bus.load_error, m_err);
    if (abort_after == 0) begin
      chk({tag, "_dw_cnt"}, dw_cnt - dw0, PB);
      chk({tag, "_ew_cnt"}, ew_cnt - ew0, 1);
      chk({tag, "_ew_lag"}, ew_cyc - dw_last, 1);
    end else begin
      chk({tag, "_dw_cnt"}, dw_cnt - dw0, abort_after + SS);
      chk({tag, "_ew_cnt"}, ew_cnt - ew0, 0);
      bus.system_enable = 1'b1;
      tick(SS + 3);
    end
    tick(SS + 2);
  endtask

  initial begin
    int dw0;
    int wait_cyc;
    logic [N-1:0] sp;
    logic [PB-1:0] rw;
    int ab;

    m_params = '0;
    m_valid  = 1'b0;
    m_err    = 1'b0;

    // 1: reset with every input high
    reset_n                    = 1'b0;
    bus.system_enable          = 1'b1;
    bus.spike_input_reg_enable = 1'b1;
    bus.rsnn_enable            = 1'b1;
    bus.load_params            = 1'b1;
    bus.data_in                = 1'b1;
    bus.input_spikes           = '1;
    #23;
    chk("rst_spikes", bus.registered_spikes, 0);
    chk("rst_params", bus.params_out, 0);
    chk("rst_valid", bus.params_valid, 0);
    chk("rst_core_en", bus.core_enable, 0);
    chk("rst_dw", bus.data_written, 0);
    chk("rst_ew", bus.end_writing, 0);
    chk("rst_err", bus.load_error, 0);
    chk("rst_ts", bus.timestep, 0);
    dw0 = dw_cnt;
    reset_n = 1'b1;
    tick(12);
    chk("post_rst_core_en", bus.core_enable, 0);
    chk("post_rst_valid", bus.params_valid, 0);
    chk("post_rst_no_load", dw_cnt - dw0, 0);
    bus.rsnn_enable            = 1'b0;
    bus.load_params            = 1'b0;
    bus.spike_input_reg_enable = 1'b0;
    bus.input_spikes           = '0;
    tick(SS + 3);

    // 2 and 3: good load, aborted load, recovery load
    run_load("load_a5", 8'hA5, 0);
    run_load("abort_3c", 8'h3C, 4);
    run_load("load_3c", 8'h3C, 0);

    // 4: core run, timestep wrap and clear
    bus.rsnn_enable = 1'b1;
    for (int n = 1; n <= 22; n++) begin
      tick(1);
      chk($sformatf("run_core_en_%0d", n), bus.core_enable, (n >= SS + 1) ? 1 : 0);
      chk($sformatf("run_ts_%0d", n), bus.timestep,
          (n >= SS + 1) ? ((n - SS - 1) % (1 << TW)) : 0);
    end
    bus.rsnn_enable = 1'b0;
    tick(SS + 2);
    chk("stop_core_en", bus.core_enable, 0);
    chk("stop_ts", bus.timestep, 0);

    // 5: spike register
    bus.spike_input_reg_enable = 1'b1;
    bus.input_spikes           = 3'b101;
    tick(SS + 2);
    chk("spk_load", bus.registered_spikes, 3'b101);
    bus.spike_input_reg_enable = 1'b0;
    tick(SS + 2);
    bus.input_spikes = 3'b010;
    tick(3);
    chk("spk_hold", bus.registered_spikes, 3'b101);
    bus.spike_input_reg_enable = 1'b1;
    tick(SS + 2);
    for (int i = 0; i < 6; i++) begin
      sp = N'($urandom_range(0, (1 << N) - 1));
      bus.input_spikes = sp;
      tick(1);
      chk($sformatf("spk_rand_%0d", i), bus.registered_spikes, sp);
    end
    bus.spike_input_reg_enable = 1'b0;

    // random good and aborted loads
    for (int i = 0; i < 10; i++) begin
      rw = PB'($urandom_range(0, (1 << PB) - 1));
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, PB - SS - 1) : 0;
      run_load($sformatf("rnd%0d", i), rw, ab);
    end

    // 6: reset in the middle of a load with load_params held high
    dw0 = dw_cnt;
    bus.data_in     = 1'b1;
    bus.load_params = 1'b1;
    wait_cyc = 0;
    while ((dw_cnt - dw0) < 3 && wait_cyc < 40) begin
      tick(1);
      wait_cyc++;
    end
    chk("mid_load_reached", (dw_cnt - dw0) >= 3, 1);
    reset_n = 1'b0;
    #2;
    m_params = '0;
    m_valid  = 1'b0;
    m_err    = 1'b0;
    chk("midrst_valid", bus.params_valid, m_valid);
    chk("midrst_params", bus.params_out, m_params);
    chk("midrst_dw", bus.data_written, 0);
    chk("midrst_err", bus.load_error, m_err);
    tick(1);
    reset_n = 1'b1;
    dw0 = dw_cnt;
    tick(20);
    chk("held_no_load", dw_cnt - dw0, 0);
    chk("held_valid", bus.params_valid, 0);
    bus.load_params = 1'b0;
    tick(SS + 3);
    run_load("after_rst", 8'h5A, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
